alu8: RTL and testbench

- 8-bit ALU for the single-cycle processor datapath. Sits between the register file and writeback/branch logic.
- Decodes a 3-bit opcode plus a 2-bit function code into arithmetic, shift, compare, move, logic and branch-compare operations.
- Result and branch-enable are registered, giving one cycle of latency.

---
 rtl/alu8.sv | 104 ++++++++++
 tb/tb_alu8.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu8.sv
// alu8: 8-bit single-cycle datapath ALU.
// A 3-bit opcode plus a 2-bit function code select one of the
// arithmetic, shift, compare, move, logic or branch-compare operations.
// The result and the branch-taken flag are registered, so the outputs
// always reflect the operands sampled at the previous rising clock edge.
// All arithmetic is unsigned modulo 256, and carries are discarded.
module alu8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] INPUTA,
    input  logic [7:0] INPUTB,
    input  logic [2:0] OP,
    input  logic [1:0] Function_code,
    output logic [7:0] OUT,
    output logic       branch_en
);

    // Opcode encodings
    localparam logic [2:0] OP_ARITH = 3'b000;
    localparam logic [2:0] OP_CMP   = 3'b001;
    localparam logic [2:0] OP_MOVE  = 3'b010;
    localparam logic [2:0] OP_INC   = 3'b011;
    localparam logic [2:0] OP_DEC   = 3'b100;
    localparam logic [2:0] OP_BEQ   = 3'b101;
    localparam logic [2:0] OP_BNE   = 3'b110;
    localparam logic [2:0] OP_LOGIC = 3'b111;

    logic [7:0] result;
    logic       branch;
    logic [2:0] shamt;
    logic [7:0] diff;

    // Only the low three bits of B form the shift amount.
    assign shamt = INPUTB[2:0];

    // A-B is shared by SUB and by both branch compares.
    assign diff  = INPUTA - INPUTB;

    // Combinational decode of opcode and function code into the next result and branch flag
    always_comb begin
        result = 8'h00;
        branch = 1'b0;
        case (OP)
            OP_ARITH: begin
                case (Function_code)
                    2'b00:   result = INPUTA + INPUTB;
                    2'b01:   result = diff;
                    2'b10:   result = INPUTA << shamt;
                    default: result = INPUTA >> shamt;
                endcase
            end
            OP_CMP: begin
                case (Function_code)
                    2'b00:   result = {7'b0, (INPUTA < INPUTB)};
                    2'b01:   result = {7'b0, ($signed(INPUTA) < $signed(INPUTB))};
                    2'b10:   result = {7'b0, (INPUTA == INPUTB)};
                    default: result = {7'b0, (INPUTA != INPUTB)};
                endcase
            end
            OP_MOVE: begin
                case (Function_code)
                    2'b00:   result = INPUTB;
                    2'b01:   result = INPUTA;
                    2'b10:   result = ~INPUTA;
                    default: result = 8'h00 - INPUTA;
                endcase
            end
            OP_INC: result = INPUTA + 8'h01;
            OP_DEC: result = INPUTA - 8'h01;
            OP_BEQ: begin
                result = diff;
                branch = (INPUTA == INPUTB);
            end
            OP_BNE: begin
                result = diff;
                branch = (INPUTA != INPUTB);
            end
            OP_LOGIC: begin
                case (Function_code)
                    2'b00:   result = INPUTA & INPUTB;
                    2'b01:   result = INPUTA | INPUTB;
                    2'b10:   result = INPUTA ^ INPUTB;
                    default: result = ~(INPUTA | INPUTB);
                endcase
            end
            default: begin
                result = 8'h00;
                branch = 1'b0;
            end
        endcase
    end

    // Output register: loads on every edge and clears asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            OUT       <= 8'h00;
            branch_en <= 1'b0;
        end else begin
            OUT       <= result;
            branch_en <= branch;
        end
    end

endmodule

// File: tb/tb_alu8.sv
// tb_alu8: directed-vector bench for alu8.
// Each feature task drives its operands, waits one edge, and then checks
// OUT and branch_en against values that were worked out by hand.
module tb_alu8;

    logic       clk;
    logic       rst_n;
    logic [7:0] INPUTA;
    logic [7:0] INPUTB;
    logic [2:0] OP;
    logic [1:0] Function_code;
    logic [7:0] OUT;
    logic       branch_en;

    int n_cmp;
    int n_err;

    alu8 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .INPUTA        (INPUTA),
        .INPUTB        (INPUTB),
        .OP            (OP),
        .Function_code (Function_code),
        .OUT           (OUT),
        .branch_en     (branch_en)
    );

    // Clock generation: 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the operands at the falling edge, then let one rising edge
    // capture them and settle 1 ns after that edge.
    task automatic drive(input logic [2:0] op, input logic [1:0] f,
                         input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        OP            = op;
        Function_code = f;
        INPUTA        = a;
        INPUTB        = b;
        @(posedge clk);
        #1;
    endtask

    // Reset clears the outputs immediately; the first edge after release loads the current inputs
    task automatic test_reset();
        rst_n = 1'b0;
        OP = 3'b000; Function_code = 2'b00; INPUTA = 8'h01; INPUTB = 8'h03;
        #3;
        n_cmp++;
        if (OUT !== 8'h00 || branch_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_immediate: got OUT=%h br=%b, expected OUT=00 br=0", OUT, branch_en);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (OUT !== 8'h00 || branch_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_held: got OUT=%h br=%b, expected OUT=00 br=0", OUT, branch_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (OUT !== 8'h00) begin
            n_err++;
            $display("FAIL reset_release_pre_edge: got OUT=%h, expected 00", OUT);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (OUT !== 8'h04 || branch_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_first_load: got OUT=%h br=%b, expected OUT=04 br=0", OUT, branch_en);
        end
    endtask

    // Non-branch operations: each table row is {op, f, a, b, expected OUT}
    task automatic test_alu_ops();
        logic [28:0] vec [0:22];
        logic [2:0]  op;
        logic [1:0]  f;
        logic [7:0]  a, b, exp;
        vec[0]  = {3'b000, 2'b00, 8'h01, 8'h03, 8'h04}; // ADD
        vec[1]  = {3'b000, 2'b01, 8'h05, 8'h03, 8'h02}; // SUB
        vec[2]  = {3'b000, 2'b10, 8'h01, 8'h13, 8'h08}; // SLL, B[7:3] ignored
        vec[3]  = {3'b000, 2'b11, 8'h11, 8'h03, 8'h02}; // SRL
        vec[4]  = {3'b000, 2'b00, 8'hFF, 8'h01, 8'h00}; // ADD wrap
        vec[5]  = {3'b000, 2'b01, 8'h00, 8'h01, 8'hFF}; // SUB wrap
        vec[6]  = {3'b001, 2'b00, 8'h01, 8'h03, 8'h01}; // SLTU true
        vec[7]  = {3'b001, 2'b00, 8'h80, 8'h01, 8'h00}; // SLTU false
        vec[8]  = {3'b001, 2'b01, 8'h80, 8'h01, 8'h01}; // SLT -128 < 1
        vec[9]  = {3'b001, 2'b10, 8'h01, 8'h03, 8'h00}; // SEQ false
        vec[10] = {3'b001, 2'b11, 8'h01, 8'h03, 8'h01}; // SNE true
        vec[11] = {3'b010, 2'b00, 8'h01, 8'h03, 8'h03}; // MOVB
        vec[12] = {3'b010, 2'b01, 8'h5A, 8'h03, 8'h5A}; // MOVA
        vec[13] = {3'b010, 2'b10, 8'h01, 8'h00, 8'hFE}; // NOT
        vec[14] = {3'b010, 2'b11, 8'h80, 8'h00, 8'h80}; // NEG of 80
        vec[15] = {3'b010, 2'b11, 8'h01, 8'h00, 8'hFF}; // NEG of 01
        vec[16] = {3'b011, 2'b10, 8'h01, 8'h00, 8'h02}; // INC, F ignored
        vec[17] = {3'b011, 2'b00, 8'hFF, 8'h00, 8'h00}; // INC wrap
        vec[18] = {3'b100, 2'b01, 8'h01, 8'h00, 8'h00}; // DEC
        vec[19] = {3'b100, 2'b00, 8'h00, 8'h00, 8'hFF}; // DEC wrap
        vec[20] = {3'b111, 2'b00, 8'h09, 8'h03, 8'h01}; // AND
        vec[21] = {3'b111, 2'b01, 8'h01, 8'h07, 8'h07}; // OR
        vec[22] = {3'b111, 2'b11, 8'h05, 8'h03, 8'hF8}; // NOR
        for (int i = 0; i < 23; i++) begin
            {op, f, a, b, exp} = vec[i];
            drive(op, f, a, b);
            n_cmp++;
            if (OUT !== exp || branch_en !== 1'b0) begin
                n_err++;
                $display("FAIL alu_op[%0d] op=%b f=%b a=%h b=%h: got OUT=%h br=%b, expected OUT=%h br=0",
                         i, op, f, a, b, OUT, branch_en, exp);
            end
        end
        drive(3'b111, 2'b10, 8'h03, 8'h03);
        n_cmp++;
        if (OUT !== 8'h00) begin
            n_err++;
            $display("FAIL xor_equal: got OUT=%h, expected 00", OUT);
        end
    endtask

    // Branch compares: each row is {op, f, a, b, expected OUT, expected branch_en}
    task automatic test_branch();
        logic [29:0] vec [0:4];
        logic [2:0]  op;
        logic [1:0]  f;
        logic [7:0]  a, b, exp;
        logic        exp_br;
        vec[0] = {3'b101, 2'b00, 8'h01, 8'h03, 8'hFE, 1'b0}; // BEQ not taken
        vec[1] = {3'b101, 2'b11, 8'h03, 8'h03, 8'h00, 1'b1}; // BEQ taken, F ignored
        vec[2] = {3'b110, 2'b00, 8'h01, 8'h03, 8'hFE, 1'b1}; // BNE taken
        vec[3] = {3'b110, 2'b10, 8'h07, 8'h07, 8'h00, 1'b0}; // BNE not taken
        vec[4] = {3'b110, 2'b00, 8'h05, 8'h02, 8'h03, 1'b1}; // BNE taken again
        for (int i = 0; i < 5; i++) begin
            {op, f, a, b, exp, exp_br} = vec[i];
            drive(op, f, a, b);
            n_cmp++;
            if (OUT !== exp || branch_en !== exp_br) begin
                n_err++;
                $display("FAIL branch[%0d] op=%b a=%h b=%h: got OUT=%h br=%b, expected OUT=%h br=%b",
                         i, op, a, b, OUT, branch_en, exp, exp_br);
            end
        end
        // A following non-branch op with equal operands must still clear the flag.
        drive(3'b001, 2'b10, 8'h05, 8'h05);
        n_cmp++;
        if (OUT !== 8'h01 || branch_en !== 1'b0) begin
            n_err++;
            $display("FAIL branch_clear: got OUT=%h br=%b, expected OUT=01 br=0", OUT, branch_en);
        end
    endtask

    // Reset pulsed between edges while branch_en is high
    task automatic test_reset_midstream();
        drive(3'b101, 2'b00, 8'h09, 8'h09);
        n_cmp++;
        if (branch_en !== 1'b1 || OUT !== 8'h00) begin
            n_err++;
            $display("FAIL mid_setup: got OUT=%h br=%b, expected OUT=00 br=1", OUT, branch_en);
        end
        drive(3'b101, 2'b00, 8'h0C, 8'h0C);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (OUT !== 8'h00 || branch_en !== 1'b0) begin
            n_err++;
            $display("FAIL mid_async_clear: got OUT=%h br=%b, expected OUT=00 br=0", OUT, branch_en);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (OUT !== 8'h00 || branch_en !== 1'b0) begin
            n_err++;
            $display("FAIL mid_held: got OUT=%h br=%b, expected OUT=00 br=0", OUT, branch_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        INPUTA = 8'h0C;
        INPUTB = 8'h0A;
        #2;
        n_cmp++;
        if (OUT !== 8'h00 || branch_en !== 1'b0) begin
            n_err++;
            $display("FAIL mid_release_pre_edge: got OUT=%h br=%b, expected OUT=00 br=0", OUT, branch_en);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (OUT !== 8'h02 || branch_en !== 1'b0) begin
            n_err++;
            $display("FAIL mid_first_load: got OUT=%h br=%b, expected OUT=02 br=0", OUT, branch_en);
        end
    endtask

    // Test sequence and final report
    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_alu_ops();
        test_branch();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
